// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: load extraction, write-data select,
// register-file write port, WB forwarding path and a retired-instruction counter.
module wb_stage #(
    parameter logic [31:0] RESET_CNT = 32'd0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mem_valid,
    input  logic        mem_regwr,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_dmem,
    input  logic [2:0]  mem_ldtype,
    input  logic [1:0]  mem_wdsel,
    input  logic [31:0] mem_pc,
    input  logic        wb_stall,
    input  logic        wb_flush,
    output logic        rf_wr,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        wb_valid,
    output logic        fwd_en,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic [31:0] retired_cnt
);

    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    logic        valid_q,  valid_d;
    logic        regwr_q,  regwr_d;
    logic [4:0]  rd_q,     rd_d;
    logic [31:0] alu_q,    alu_d;
    logic [31:0] dmem_q,   dmem_d;
    logic [2:0]  ldtype_q, ldtype_d;
    logic [1:0]  wdsel_q,  wdsel_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] cnt_q,    cnt_d;
    logic        retire;
    logic [31:0] load_val;
    logic [31:0] wd;

    // Little-endian sub-word extraction; a[0] is ignored for halfwords, no alignment trap.
    function automatic logic [31:0] load_extract(input logic [2:0]  ldtype,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (ldtype)
            LD_LH:   load_extract = {{16{h[15]}}, h};
            LD_LHU:  load_extract = {16'h0000, h};
            LD_LB:   load_extract = {{24{b[7]}}, b};
            LD_LBU:  load_extract = {24'h000000, b};
            default: load_extract = w;
        endcase
    endfunction

    always_comb begin
        valid_d  = valid_q;
        regwr_d  = regwr_q;
        rd_d     = rd_q;
        alu_d    = alu_q;
        dmem_d   = dmem_q;
        ldtype_d = ldtype_q;
        wdsel_d  = wdsel_q;
        pc_d     = pc_q;
        if (wb_flush) begin
            valid_d  = 1'b0;
            regwr_d  = 1'b0;
            rd_d     = '0;
            alu_d    = '0;
            dmem_d   = '0;
            ldtype_d = '0;
            wdsel_d  = '0;
            pc_d     = '0;
        end else if (!wb_stall) begin
            valid_d  = mem_valid;
            regwr_d  = mem_regwr;
            rd_d     = mem_rd;
            alu_d    = mem_alu;
            dmem_d   = mem_dmem;
            ldtype_d = mem_ldtype;
            wdsel_d  = mem_wdsel;
            pc_d     = mem_pc;
        end
    end

    // A flush retires the instruction already in WB; only the incoming one is dropped.
    assign retire = valid_q & (~wb_stall | wb_flush);
    assign cnt_d  = cnt_q + {31'd0, retire};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q  <= 1'b0;
            regwr_q  <= 1'b0;
            rd_q     <= '0;
            alu_q    <= '0;
            dmem_q   <= '0;
            ldtype_q <= '0;
            wdsel_q  <= '0;
            pc_q     <= '0;
            cnt_q    <= RESET_CNT;
        end else begin
            valid_q  <= valid_d;
            regwr_q  <= regwr_d;
            rd_q     <= rd_d;
            alu_q    <= alu_d;
            dmem_q   <= dmem_d;
            ldtype_q <= ldtype_d;
            wdsel_q  <= wdsel_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign load_val = load_extract(ldtype_q, alu_q[1:0], dmem_q);

    always_comb begin
        case (wdsel_q)
            2'd1:    wd = load_val;
            2'd2:    wd = pc_q + 32'd8;
            default: wd = alu_q;
        endcase
    end

    assign rf_wr       = valid_q & regwr_q & (rd_q != 5'd0);
    assign rf_a3       = rd_q;
    assign rf_wd       = wd;
    assign wb_valid    = valid_q;
    assign fwd_en      = rf_wr;
    assign fwd_rd      = rf_a3;
    assign fwd_data    = rf_wd;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: writeback select, load extraction, stall/flush,
// asynchronous reset and retired counter wrap (second instance preset near the top).
module tb_wb_stage;

    logic        clk;
    logic        clrn;
    logic        mem_valid;
    logic        mem_regwr;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu;
    logic [31:0] mem_dmem;
    logic [2:0]  mem_ldtype;
    logic [1:0]  mem_wdsel;
    logic [31:0] mem_pc;
    logic        wb_stall;
    logic        wb_flush;

    logic        rf_wr, wb_valid, fwd_en;
    logic [4:0]  rf_a3, fwd_rd;
    logic [31:0] rf_wd, fwd_data, retired_cnt;

    logic        w_rf_wr, w_wb_valid, w_fwd_en;
    logic [4:0]  w_rf_a3, w_fwd_rd;
    logic [31:0] w_rf_wd, w_fwd_data, w_retired_cnt;

    int checks = 0;
    int errors = 0;

    wb_stage u_dut (
        .clk(clk), .clrn(clrn),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rd(mem_rd),
        .mem_alu(mem_alu), .mem_dmem(mem_dmem), .mem_ldtype(mem_ldtype),
        .mem_wdsel(mem_wdsel), .mem_pc(mem_pc),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .wb_valid(wb_valid),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired_cnt(retired_cnt)
    );

    wb_stage #(.RESET_CNT(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .clrn(clrn),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rd(mem_rd),
        .mem_alu(mem_alu), .mem_dmem(mem_dmem), .mem_ldtype(mem_ldtype),
        .mem_wdsel(mem_wdsel), .mem_pc(mem_pc),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .rf_wr(w_rf_wr), .rf_a3(w_rf_a3), .rf_wd(w_rf_wd), .wb_valid(w_wb_valid),
        .fwd_en(w_fwd_en), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
        .retired_cnt(w_retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_idle();
        mem_valid  = 1'b0;
        mem_regwr  = 1'b0;
        mem_rd     = 5'd0;
        mem_alu    = 32'h0;
        mem_dmem   = 32'h0;
        mem_ldtype = 3'd0;
        mem_wdsel  = 2'd0;
        mem_pc     = 32'h0;
    endtask

    task automatic mem_instr(input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] dmem, input logic [2:0] ldt,
                             input logic [1:0] wdsel, input logic [31:0] pc);
        mem_valid  = 1'b1;
        mem_regwr  = 1'b1;
        mem_rd     = rd;
        mem_alu    = alu;
        mem_dmem   = dmem;
        mem_ldtype = ldt;
        mem_wdsel  = wdsel;
        mem_pc     = pc;
    endtask

    task automatic load_check(input string tag, input logic [2:0] ldt,
                              input logic [1:0] a, input logic [31:0] exp);
        mem_instr(5'd3, {30'd0, a}, 32'h80FF_7F01, ldt, 2'd1, 32'h0000_0100);
        tick();
        check(tag, rf_wd, exp);
    endtask

    initial begin
        mem_idle();
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        clrn     = 1'b0;
        #12;
        check("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("rst_rf_a3", {27'd0, rf_a3}, 32'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_fwd_en", {31'd0, fwd_en}, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        check("rst_wrap_cnt", w_retired_cnt, 32'hFFFF_FFFF);
        #1 clrn = 1'b1;

        // Basic ALU writeback and one-cycle latency
        mem_instr(5'd5, 32'h0000_1234, 32'h0, 3'd0, 2'd0, 32'h0);
        tick();
        mem_idle();
        check("alu_rf_wr", {31'd0, rf_wr}, 32'd1);
        check("alu_rf_a3", {27'd0, rf_a3}, 32'd5);
        check("alu_rf_wd", rf_wd, 32'h0000_1234);
        check("alu_fwd_en", {31'd0, fwd_en}, 32'd1);
        check("alu_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        check("alu_fwd_data", fwd_data, 32'h0000_1234);
        check("alu_cnt_pre", retired_cnt, 32'd0);
        tick();
        check("alu_valid_after", {31'd0, wb_valid}, 32'd0);
        check("alu_cnt_after", retired_cnt, 32'd1);
        check("wrap_to_zero", w_retired_cnt, 32'd0);

        // Loads from 80FF7F01
        load_check("lb_a1", 3'd3, 2'd1, 32'h0000_007F);
        load_check("lb_a2", 3'd3, 2'd2, 32'hFFFF_FFFF);
        load_check("lbu_a3", 3'd4, 2'd3, 32'h0000_0080);
        load_check("lh_a2", 3'd1, 2'd2, 32'hFFFF_80FF);
        load_check("lhu_a0", 3'd2, 2'd0, 32'h0000_7F01);
        load_check("lw", 3'd0, 2'd3, 32'h80FF_7F01);
        load_check("ldtype7_as_lw", 3'd7, 2'd1, 32'h80FF_7F01);

        // Link writeback wraps modulo 2^32
        mem_instr(5'd31, 32'h0, 32'h0, 3'd0, 2'd2, 32'hFFFF_FFFC);
        tick();
        check("link_rf_wd", rf_wd, 32'h0000_0004);
        check("link_rf_a3", {27'd0, rf_a3}, 32'd31);

        // Write to r0 is suppressed but still retires
        mem_instr(5'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0, 32'h0);
        tick();
        mem_idle();
        check("r0_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("r0_valid", {31'd0, wb_valid}, 32'd1);
        check("r0_rf_wd", rf_wd, 32'hDEAD_BEEF);
        tick();
        check("r0_cnt", retired_cnt, 32'd10);

        // Stall holds the write port; flush during stall retires and bubbles
        mem_instr(5'd7, 32'h0000_0077, 32'h0, 3'd0, 2'd0, 32'h0);
        tick();
        mem_instr(5'd9, 32'h0000_0099, 32'h0, 3'd0, 2'd0, 32'h0);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rf_wr", {31'd0, rf_wr}, 32'd1);
            check("stall_rf_a3", {27'd0, rf_a3}, 32'd7);
            check("stall_rf_wd", rf_wd, 32'h0000_0077);
            check("stall_cnt", retired_cnt, 32'd10);
        end
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        wb_stall = 1'b0;
        mem_idle();
        check("flush_cnt", retired_cnt, 32'd11);
        check("flush_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_rf_wd", rf_wd, 32'd0);

        // Asynchronous reset mid-cycle while writing
        mem_instr(5'd4, 32'h0000_0044, 32'h0, 3'd0, 2'd0, 32'h0);
        tick();
        mem_idle();
        check("pre_arst_rf_wr", {31'd0, rf_wr}, 32'd1);
        #2 clrn = 1'b0;
        #1;
        check("arst_rf_wr", {31'd0, rf_wr}, 32'd0);
        check("arst_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_cnt", retired_cnt, 32'd0);
        check("arst_wrap_cnt", w_retired_cnt, 32'hFFFF_FFFF);
        #1 clrn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
